frame_config_writer: RTL

//  Configuration-side writer for the fabric's frame-based config memories: consumes a bitstream word

---
 rtl/frame_cfg_pkg.sv | 25 ++
 rtl/frame_strobe_decoder.sv | 25 ++
 rtl/frame_config_writer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the frame configuration writer: FSM states,
// command opcodes, header field positions and the default sync word.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam logic [3:0] OP_DESYNC = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;

    localparam int OPCODE_LSB = 28;
    localparam int OPCODE_W   = 4;
    localparam int COLUMN_LSB = 8;
    localparam int COLUMN_W   = 8;
    localparam int FRAME_LSB  = 0;
    localparam int FRAME_W    = 5;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational (column, frame, enable) -> onehot0 strobe decode; the parent
// registers the result so FrameStrobe stays glitch-free.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 8
) (
    input  logic [COLUMN_W-1:0]                   column,
    input  logic [FRAME_W-1:0]                    frame,
    input  logic                                  enable,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

    generate
        for (genvar gi = 0; gi < NumColumns; gi++) begin : g_col
            for (genvar gj = 0; gj < MaxFramesPerCol; gj++) begin : g_frame
                assign strobe[gi*MaxFramesPerCol + gj] = enable
                    && (column == COLUMN_W'(gi))
                    && (frame == FRAME_W'(gj));
            end
        end
    endgenerate

endmodule

// File: rtl/frame_config_writer.sv
// Bitstream-to-frame writer: parses sync/header/data words, fills the FrameData
// rows and pulses a single FrameStrobe bit per written frame.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int                         FrameBitsPerRow = 32,
    parameter int                         MaxFramesPerCol = 20,
    parameter int                         NumRows         = 16,
    parameter int                         NumColumns      = 8,
    parameter logic [FrameBitsPerRow-1:0] SyncWord        = DEFAULT_SYNC_WORD
) (
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    input  logic [FrameBitsPerRow-1:0]            s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  synced,
    output logic                                  error,
    output logic [15:0]                           frames_written
);

    localparam int ROW_W      = $clog2(NumRows);
    localparam int NUM_STROBE = NumColumns * MaxFramesPerCol;

    state_t                              state_reg;
    logic [ROW_W-1:0]                    row_cnt_reg;
    logic [COLUMN_W-1:0]                 column_reg;
    logic [FRAME_W-1:0]                  frame_reg;
    logic                                addr_ok_reg;
    logic [NumRows*FrameBitsPerRow-1:0]  frame_data_reg;
    logic [NUM_STROBE-1:0]               frame_strobe_reg;
    logic                                s_ready_reg;
    logic                                synced_reg;
    logic                                error_reg;
    logic [15:0]                         frames_written_reg;

    logic [OPCODE_W-1:0]   hdr_opcode;
    logic [COLUMN_W-1:0]   hdr_column;
    logic [FRAME_W-1:0]    hdr_frame;
    logic                  hdr_addr_ok;
    logic                  accept;
    logic                  last_row;
    logic [NUM_STROBE-1:0] strobe_next;

    assign hdr_opcode  = s_data[OPCODE_LSB +: OPCODE_W];
    assign hdr_column  = s_data[COLUMN_LSB +: COLUMN_W];
    assign hdr_frame   = s_data[FRAME_LSB +: FRAME_W];
    assign hdr_addr_ok = (int'(hdr_column) < NumColumns) && (int'(hdr_frame) < MaxFramesPerCol);
    assign accept      = s_valid && s_ready_reg;
    assign last_row    = (row_cnt_reg == ROW_W'(NumRows - 1));

    // Invalid targets decode to all-zero, which is how the strobe is suppressed.
    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .NumColumns     (NumColumns)
    ) u_decoder (
        .column(column_reg),
        .frame (frame_reg),
        .enable(addr_ok_reg),
        .strobe(strobe_next)
    );

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_reg          <= ST_IDLE;
            row_cnt_reg        <= '0;
            column_reg         <= '0;
            frame_reg          <= '0;
            addr_ok_reg        <= 1'b0;
            frame_data_reg     <= '0;
            frame_strobe_reg   <= '0;
            s_ready_reg        <= 1'b1;
            synced_reg         <= 1'b0;
            error_reg          <= 1'b0;
            frames_written_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && (s_data == SyncWord)) begin
                        synced_reg <= 1'b1;
                        state_reg  <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (accept) begin
                        case (hdr_opcode)
                            OP_WRITE: begin
                                state_reg   <= ST_DATA;
                                row_cnt_reg <= '0;
                                column_reg  <= hdr_column;
                                frame_reg   <= hdr_frame;
                                addr_ok_reg <= hdr_addr_ok;
                                if (!hdr_addr_ok)
                                    error_reg <= 1'b1;
                            end
                            OP_DESYNC: begin
                                synced_reg <= 1'b0;
                                state_reg  <= ST_IDLE;
                            end
                            default: error_reg <= 1'b1;
                        endcase
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        frame_data_reg[row_cnt_reg*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                        row_cnt_reg <= row_cnt_reg + ROW_W'(1);
                        if (last_row) begin
                            state_reg        <= ST_STROBE;
                            s_ready_reg      <= 1'b0;
                            frame_strobe_reg <= strobe_next;
                            if (addr_ok_reg)
                                frames_written_reg <= frames_written_reg + 16'd1;
                        end
                    end
                end
                ST_STROBE: begin
                    frame_strobe_reg <= '0;
                    state_reg        <= ST_HOLD;
                end
                ST_HOLD: begin
                    s_ready_reg <= 1'b1;
                    state_reg   <= ST_HEADER;
                end
                default: begin
                    frame_strobe_reg <= '0;
                    s_ready_reg      <= 1'b1;
                    state_reg        <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready        = s_ready_reg;
    assign FrameData      = frame_data_reg;
    assign FrameStrobe    = frame_strobe_reg;
    assign synced         = synced_reg;
    assign error          = error_reg;
    assign frames_written = frames_written_reg;

endmodule
